alu_operand_sequencer: RTL



---
 rtl/alu_operand_sequencer_pkg.sv | 32 +++
 rtl/key_debouncer.sv | 48 ++++
 rtl/alu_operand_sequencer.sv | 95 +++++++++
 3 files changed

// File: rtl/alu_operand_sequencer_pkg.sv
// Shared step encodings, opcode set and operand bundle for the
// operand entry sequencer and the downstream ALU.
package alu_operand_sequencer_pkg;

    localparam logic [1:0] S_A    = 2'd0;
    localparam logic [1:0] S_B    = 2'd1;
    localparam logic [1:0] S_OP   = 2'd2;
    localparam logic [1:0] S_SHOW = 2'd3;

    localparam logic [2:0] OP_AND       = 3'b000;
    localparam logic [2:0] OP_OR        = 3'b001;
    localparam logic [2:0] OP_ADD       = 3'b010;
    localparam logic [2:0] OP_SUB       = 3'b011;
    localparam logic [2:0] OP_MUL2      = 3'b100;
    localparam logic [2:0] OP_DIV2      = 3'b101;
    localparam logic [2:0] OP_MAX_LEGAL = OP_DIV2;

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
        logic [2:0] op;
    } operands_t;

    function automatic logic opcode_legal(input logic [2:0] op);
        return op <= OP_MAX_LEGAL;
    endfunction

    function automatic logic [3:0] step_leds(input logic [1:0] s);
        return 4'b0001 << s;
    endfunction

endpackage

// File: rtl/key_debouncer.sv
// Pushbutton conditioner: 2-FF synchronizer, stability counter and a
// single-cycle pulse on each accepted press (active-low key).
module key_debouncer #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic press
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             meta;
    logic             sync;
    logic             level;
    logic [CNT_W-1:0] cnt;
    logic             mismatch;
    logic             expire;

    assign mismatch = sync != level;
    assign expire   = mismatch && (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta  <= 1'b1;
            sync  <= 1'b1;
            level <= 1'b1;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            meta  <= key_n;
            sync  <= meta;
            // only the 1->0 flip of the accepted level is a press
            press <= expire && !sync;
            if (expire) begin
                level <= sync;
                cnt   <= '0;
            end else if (mismatch) begin
                cnt <= cnt + CNT_W'(1);
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/alu_operand_sequencer.sv
// Operand entry sequencer: steps through A, B and opcode on each enter
// press and holds the completed set for the ALU until the next press.
module alu_operand_sequencer
    import alu_operand_sequencer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
) (
    input  logic        CLOCK_50,
    input  logic        RST_N,
    input  logic [17:0] SW,
    input  logic [3:0]  KEY,
    output logic [3:0]  OP_A,
    output logic [3:0]  OP_B,
    output logic [2:0]  OPCODE,
    output logic        VALID,
    output logic [3:0]  LEDG
);

    logic      enter_p;
    logic      clear_p;
    logic [1:0] state;
    logic [1:0] state_d;
    operands_t ops;
    operands_t ops_d;
    logic      unused;

    assign unused = ^{SW[17:8], SW[3], KEY[3], KEY[0]};

    key_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_enter (
        .clk  (CLOCK_50),
        .rst_n(RST_N),
        .key_n(KEY[1]),
        .press(enter_p)
    );

    key_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_clear (
        .clk  (CLOCK_50),
        .rst_n(RST_N),
        .key_n(KEY[2]),
        .press(clear_p)
    );

    always_comb begin
        state_d = state;
        ops_d   = ops;
        if (clear_p) begin
            state_d = S_A;
            ops_d   = '0;
        end else if (enter_p) begin
            unique case (state)
                S_A: begin
                    ops_d.a = SW[7:4];
                    state_d = S_B;
                end
                S_B: begin
                    ops_d.b = SW[7:4];
                    state_d = S_OP;
                end
                S_OP: begin
                    if (opcode_legal(SW[2:0])) begin
                        ops_d.op = SW[2:0];
                        state_d  = S_SHOW;
                    end
                end
                S_SHOW: begin
                    state_d = S_A;
                end
            endcase
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RST_N) begin
        if (!RST_N) begin
            state <= S_A;
            ops   <= '0;
        end else begin
            state <= state_d;
            ops   <= ops_d;
        end
    end

    assign OP_A   = ops.a;
    assign OP_B   = ops.b;
    assign OPCODE = ops.op;
    assign VALID  = state == S_SHOW;
    assign LEDG   = step_leds(state);

endmodule
